vx_barrier_ctrl: RTL and testbench
==================================

Name: vx_barrier_ctrl

Overview:
Consumes barrier requests (the gpu_barrier_t fields plus the issuing warp id) from the warp-control execute stage. Tracks which warps have arrived at each hardware barrier. When the required count is reached, it emits a registered release mask to the warp scheduler. Sits between the GPU execute unit and the warp scheduler's stall logic.

Parameters:
NUM_WARPS, 4, warps per core (power of two, ≥2)
NUM_BARRIERS, 4, hardware barriers per core (power of two, ≥1)
NW_BITS, clog2(NUM_WARPS), warp id width
NB_BITS, clog2(NUM_BARRIERS), barrier id width (UP()'d to ≥1)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
barrier_valid  in  1  arrival request valid
barrier_ready  out  1  arrival accepted when valid&ready
barrier_id  in  NB_BITS  barrier index (gpu_barrier_t.id)
barrier_size_m1  in  UP(NW_BITS)  participating warps minus one (gpu_barrier_t.size_m1)
barrier_wid  in  NW_BITS  arriving warp id
release_valid  out  1  release mask valid
release_ready  in  1  scheduler accepts release
release_id  out  NB_BITS  barrier being released
release_wmask  out  NUM_WARPS  warps to unstall
stalled_wmask  out  NUM_WARPS  OR of all barrier masks (warps currently parked)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: all barrier masks=0, size regs=0, busy bits=0; release_valid=0, release_id=0, release_wmask=0; stalled_wmask=0; barrier_ready=1.
- State per barrier b: mask[b] (NUM_WARPS), size_m1[b], busy[b].
- barrier_ready = !release_valid | release_ready. This is combinational, and only one arrival is accepted per cycle.
- Accepted arrival to barrier b, warp w:
  - eff_size = busy[b] ? size_m1[b] : barrier_size_m1. The first arrival latches its size. Later arrivals ignore their size field, and a mismatch fires a simulation assertion only.
  - new_mask = mask[b] | (1<<w); cnt = popcount(new_mask), computed at width NW_BITS+1.
  - If cnt == eff_size+1, the barrier completes:
    - Next cycle: release_valid=1, release_id=b, release_wmask=new_mask.
    - mask[b], busy[b] and size_m1[b] are cleared in the same edge.
  - Otherwise: mask[b]=new_mask, busy[b]=1, size_m1[b]=eff_size. No release is generated.
- size_m1=0: single-warp barrier. It releases immediately with release_wmask=(1<<w) and never parks.
- Arrival by a warp already set in mask[b]: illegal, assertion only. Hardware OR is idempotent, so the count is unchanged.
- cnt > eff_size+1 cannot occur legally; the compare is equality, plus an assertion.
- Release handshake:
  - release_valid holds with stable id/mask until release_valid&release_ready, then drops next cycle unless a new completion occurs in the same cycle.
  - A new completion in the handshake cycle reloads the release register back-to-back: release_valid stays 1 with the new id/mask.
- stalled_wmask is registered: it is the OR of all mask[b] after the edge. A completing warp never appears in stalled_wmask; the release register covers it.
- Barriers are independent: arrivals to b≠b' never disturb each other's state.
- Reset asserted mid-operation clears all state asynchronously and drops any pending release. The scheduler is reset by the same signal.
- Latency: arrival→release_valid is exactly 1 cycle when barrier_ready was 1.

Decomposition:
- Shared package (existing GPU types package): gpu_barrier_t is reused as the input bundle. Add localparam BAR_MASK_W=NUM_WARPS and a typedef barrier_entry_t {busy, size_m1, mask}, used for the per-barrier state array.
- No new sub-module. Population count uses the codebase's existing popcount helper, one instance on new_mask. The release output register is an inline elastic stage.

Test Plan:
1. Reset, idle: all outputs 0, barrier_ready=1; no activity for 10 cycles -> release_valid never asserts.
2. NUM_WARPS=4, id=1, size_m1=3; warps 0,2,1 arrive on consecutive cycles -> stalled_wmask=0001,0101,0111; warp 3 arrives -> next cycle release_valid=1, release_id=1, release_wmask=1111, stalled_wmask=0000.
3. Arrival with size_m1=0 from warp 2 to id=0 -> next cycle release_wmask=0100; stalled_wmask stays 0000.
4. Interleaved barriers: id=0 size_m1=1 gets warps 0,1 and id=3 size_m1=1 gets warps 2,3, alternating -> two releases, masks 0011 (id 0) and 1100 (id 3), in completion order; no cross-contamination.
5. Backpressure: release pending with release_ready=0 for 3 cycles -> barrier_ready=0, arrivals not accepted, release_id/release_wmask stable. Raise release_ready while a completing arrival is valid -> back-to-back release with release_valid held high.
6. Reset asserted asynchronously mid-cycle with id=2 holding mask 0110 -> outputs clear immediately without a clock edge. After deassert, warp 1 arrival with size_m1=1 parks (stalled_wmask=0010) rather than completing.

Source files
------------

// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared GPU types for the barrier controller: core geometry, request bundle,
// per-barrier state entry and the popcount helper.
package vx_barrier_ctrl_pkg;

  localparam int unsigned NUM_WARPS    = 4;
  localparam int unsigned NUM_BARRIERS = 4;
  localparam int unsigned NW_BITS      = $clog2(NUM_WARPS);
  localparam int unsigned NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int unsigned SIZE_W       = (NW_BITS > 0) ? NW_BITS : 1;
  localparam int unsigned BAR_MASK_W   = NUM_WARPS;

  typedef struct packed {
    logic [NB_BITS-1:0] id;
    logic [SIZE_W-1:0]  size_m1;
  } gpu_barrier_t;

  typedef struct packed {
    logic                  busy;
    logic [SIZE_W-1:0]     size_m1;
    logic [BAR_MASK_W-1:0] mask;
  } barrier_entry_t;

  function automatic logic [NW_BITS:0] popcount(input logic [BAR_MASK_W-1:0] v);
    logic [NW_BITS:0] c;
    c = '0;
    for (int i = 0; i < BAR_MASK_W; i++) begin
      c = c + (NW_BITS + 1)'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/vx_barrier_ctrl.sv
// Per-core warp barrier tracker: collects arrivals per hardware barrier and
// hands a registered release mask to the warp scheduler once the count is met.
module vx_barrier_ctrl
  import vx_barrier_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  barrier_valid_i,
  output logic                  barrier_ready_o,
  input  logic [NB_BITS-1:0]    barrier_id_i,
  input  logic [SIZE_W-1:0]     barrier_size_m1_i,
  input  logic [NW_BITS-1:0]    barrier_wid_i,
  output logic                  release_valid_o,
  input  logic                  release_ready_i,
  output logic [NB_BITS-1:0]    release_id_o,
  output logic [NUM_WARPS-1:0]  release_wmask_o,
  output logic [NUM_WARPS-1:0]  stalled_wmask_o
);

  gpu_barrier_t          req;
  barrier_entry_t        bar_q [NUM_BARRIERS];
  barrier_entry_t        bar_d [NUM_BARRIERS];
  barrier_entry_t        cur;

  logic                  rel_valid_q, rel_valid_d;
  logic [NB_BITS-1:0]    rel_id_q, rel_id_d;
  logic [BAR_MASK_W-1:0] rel_mask_q, rel_mask_d;
  logic [BAR_MASK_W-1:0] stalled_q, stalled_d;

  logic                  accept;
  logic                  complete;
  logic [SIZE_W-1:0]     eff_size;
  logic [BAR_MASK_W-1:0] wbit;
  logic [BAR_MASK_W-1:0] new_mask;
  logic [NW_BITS:0]      cnt;

  assign req = '{id: barrier_id_i, size_m1: barrier_size_m1_i};

  // Release register is an elastic stage: it can accept a new completion in the
  // same cycle its current content is consumed.
  assign barrier_ready_o = ~rel_valid_q | release_ready_i;
  assign accept          = barrier_valid_i & barrier_ready_o;

  assign cur      = bar_q[req.id];
  assign eff_size = cur.busy ? cur.size_m1 : req.size_m1;
  assign wbit     = BAR_MASK_W'(1) << barrier_wid_i;
  assign new_mask = cur.mask | wbit;
  assign cnt      = popcount(new_mask);
  assign complete = accept && (cnt == ((NW_BITS + 1)'(eff_size) + (NW_BITS + 1)'(1)));

  always_comb begin
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      bar_d[b] = bar_q[b];
    end
    if (accept) begin
      if (complete) begin
        bar_d[req.id] = '0;
      end else begin
        bar_d[req.id] = '{busy: 1'b1, size_m1: eff_size, mask: new_mask};
      end
    end
  end

  always_comb begin
    stalled_d = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled_d = stalled_d | bar_d[b].mask;
    end
  end

  always_comb begin
    rel_valid_d = complete | (rel_valid_q & ~release_ready_i);
    rel_id_d    = complete ? req.id : rel_id_q;
    rel_mask_d  = complete ? new_mask : rel_mask_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_q[b] <= '0;
      end
      rel_valid_q <= 1'b0;
      rel_id_q    <= '0;
      rel_mask_q  <= '0;
      stalled_q   <= '0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_q[b] <= bar_d[b];
      end
      rel_valid_q <= rel_valid_d;
      rel_id_q    <= rel_id_d;
      rel_mask_q  <= rel_mask_d;
      stalled_q   <= stalled_d;
    end
  end

  assign release_valid_o = rel_valid_q;
  assign release_id_o    = rel_id_q;
  assign release_wmask_o = rel_mask_q;
  assign stalled_wmask_o = stalled_q;

`ifndef SYNTHESIS
  // Protocol checks on the issuing side; hardware tolerates these silently.
  a_size_match : assert property (@(posedge clk_i) disable iff (reset_i)
    (accept && cur.busy) |-> (req.size_m1 == cur.size_m1))
    else $error("barrier size_m1 differs from latched size");
  a_no_dup_arrival : assert property (@(posedge clk_i) disable iff (reset_i)
    accept |-> ((cur.mask & wbit) == '0))
    else $error("warp arrived twice at the same barrier");
  a_no_overcount : assert property (@(posedge clk_i) disable iff (reset_i)
    accept |-> (cnt <= ((NW_BITS + 1)'(eff_size) + (NW_BITS + 1)'(1))))
    else $error("barrier arrival count exceeds participant count");
`endif

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench for vx_barrier_ctrl: directed vector table, hand-written
// corner sequences and random legal traffic against a queue-based model.
module tb_vx_barrier_ctrl;
  import vx_barrier_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 barrier_valid;
  logic                 barrier_ready;
  logic [NB_BITS-1:0]   barrier_id;
  logic [SIZE_W-1:0]    barrier_size_m1;
  logic [NW_BITS-1:0]   barrier_wid;
  logic                 release_valid;
  logic                 release_ready;
  logic [NB_BITS-1:0]   release_id;
  logic [NUM_WARPS-1:0] release_wmask;
  logic [NUM_WARPS-1:0] stalled_wmask;

  int checks   = 0;
  int failures = 0;

  vx_barrier_ctrl dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .barrier_valid_i  (barrier_valid),
    .barrier_ready_o  (barrier_ready),
    .barrier_id_i     (barrier_id),
    .barrier_size_m1_i(barrier_size_m1),
    .barrier_wid_i    (barrier_wid),
    .release_valid_o  (release_valid),
    .release_ready_i  (release_ready),
    .release_id_o     (release_id),
    .release_wmask_o  (release_wmask),
    .stalled_wmask_o  (stalled_wmask)
  );

  always #5 clk = ~clk;

  // Reference model: list of arrived warps per barrier plus its latched size.
  int                   arr_q [NUM_BARRIERS][$];
  int                   sz    [NUM_BARRIERS];
  logic                 m_rv;
  logic [NB_BITS-1:0]   m_rid;
  logic [NUM_WARPS-1:0] m_rmask;

  typedef struct {
    logic                 v;
    logic [NB_BITS-1:0]   id;
    logic [SIZE_W-1:0]    sz;
    logic [NW_BITS-1:0]   w;
    logic                 rr;
    logic                 erv;
    logic [NB_BITS-1:0]   erid;
    logic [NUM_WARPS-1:0] emask;
    logic [NUM_WARPS-1:0] estall;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic v, input int id, input int s, input int w,
                              input logic rr, input logic erv, input int erid,
                              input logic [NUM_WARPS-1:0] emask,
                              input logic [NUM_WARPS-1:0] estall);
    vec_t r;
    r.v = v; r.id = NB_BITS'(id); r.sz = SIZE_W'(s); r.w = NW_BITS'(w); r.rr = rr;
    r.erv = erv; r.erid = NB_BITS'(erid); r.emask = emask; r.estall = estall;
    return r;
  endfunction

  function automatic logic [NUM_WARPS-1:0] mask_of(input int b);
    logic [NUM_WARPS-1:0] m;
    m = '0;
    foreach (arr_q[b][k]) m[arr_q[b][k]] = 1'b1;
    return m;
  endfunction

  function automatic logic [NUM_WARPS-1:0] model_stalled();
    logic [NUM_WARPS-1:0] m;
    m = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) m = m | mask_of(b);
    return m;
  endfunction

  function automatic bit in_list(input int b, input int w);
    foreach (arr_q[b][k]) if (arr_q[b][k] == w) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      arr_q[b].delete();
      sz[b] = 0;
    end
    m_rv = 1'b0; m_rid = '0; m_rmask = '0;
  endtask

  task automatic model_update(input bit acc, input int id, input int s, input int w,
                              input bit rr);
    if (m_rv && rr) m_rv = 1'b0;
    if (acc) begin
      if (arr_q[id].size() == 0) sz[id] = s;
      arr_q[id].push_back(w);
      if (arr_q[id].size() == sz[id] + 1) begin
        m_rv    = 1'b1;
        m_rid   = NB_BITS'(id);
        m_rmask = mask_of(id);
        arr_q[id].delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("release_valid", 32'(release_valid), 32'(m_rv));
    if (m_rv) begin
      chk("release_id", 32'(release_id), 32'(m_rid));
      chk("release_wmask", 32'(release_wmask), 32'(m_rmask));
    end
    chk("stalled_wmask", 32'(stalled_wmask), 32'(model_stalled()));
  endtask

  // Called 1ns after a rising edge; returns 1ns after the next one.
  task automatic cycle(input bit v, input int id, input int s, input int w, input bit rr);
    bit exp_ready;
    barrier_valid   = v;
    barrier_id      = NB_BITS'(id);
    barrier_size_m1 = SIZE_W'(s);
    barrier_wid     = NW_BITS'(w);
    release_ready   = rr;
    #1;
    exp_ready = !m_rv || rr;
    chk("barrier_ready", 32'(barrier_ready), 32'(exp_ready));
    @(posedge clk);
    model_update(v && exp_ready, id, s, w, rr);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    barrier_valid = 1'b0; barrier_id = '0; barrier_size_m1 = '0; barrier_wid = '0;
    release_ready = 1'b1;
    model_reset();

    vecs[0] = mk(1, 1, 3, 0, 1, 0, 0, 4'b0000, 4'b0001);
    vecs[1] = mk(1, 1, 3, 2, 1, 0, 0, 4'b0000, 4'b0101);
    vecs[2] = mk(1, 1, 3, 1, 1, 0, 0, 4'b0000, 4'b0111);
    vecs[3] = mk(1, 1, 3, 3, 1, 1, 1, 4'b1111, 4'b0000);
    vecs[4] = mk(1, 0, 0, 2, 1, 1, 0, 4'b0100, 4'b0000);
    vecs[5] = mk(1, 0, 1, 0, 1, 0, 0, 4'b0000, 4'b0001);
    vecs[6] = mk(1, 3, 1, 2, 1, 0, 0, 4'b0000, 4'b0101);
    vecs[7] = mk(1, 0, 1, 1, 1, 1, 0, 4'b0011, 4'b0100);
    vecs[8] = mk(1, 3, 1, 3, 1, 1, 3, 4'b1100, 4'b0000);
    vecs[9] = mk(0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0000);

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("reset_release_valid", 32'(release_valid), 32'd0);
    chk("reset_release_id", 32'(release_id), 32'd0);
    chk("reset_release_wmask", 32'(release_wmask), 32'd0);
    chk("reset_stalled", 32'(stalled_wmask), 32'd0);
    chk("reset_barrier_ready", 32'(barrier_ready), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("idle_release_valid", 32'(release_valid), 32'd0);
    end

    // Directed vectors: full barrier, single-warp barrier, interleaved barriers
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].id, vecs[i].sz, vecs[i].w, vecs[i].rr);
      chk($sformatf("vec%0d_release_valid", i), 32'(release_valid), 32'(vecs[i].erv));
      if (vecs[i].erv) begin
        chk($sformatf("vec%0d_release_id", i), 32'(release_id), 32'(vecs[i].erid));
        chk($sformatf("vec%0d_release_wmask", i), 32'(release_wmask), 32'(vecs[i].emask));
      end
      chk($sformatf("vec%0d_stalled", i), 32'(stalled_wmask), 32'(vecs[i].estall));
    end

    // Backpressure, then back-to-back reload on the handshake cycle
    cycle(1, 1, 1, 0, 0);
    check_model();
    cycle(1, 1, 1, 1, 0);
    chk("bp_release_wmask", 32'(release_wmask), 32'(4'b0011));
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 0, 3, 0);
      chk("bp_hold_valid", 32'(release_valid), 32'd1);
      chk("bp_hold_id", 32'(release_id), 32'd1);
      chk("bp_hold_wmask", 32'(release_wmask), 32'(4'b0011));
    end
    cycle(1, 2, 0, 3, 1);
    chk("b2b_valid", 32'(release_valid), 32'd1);
    chk("b2b_id", 32'(release_id), 32'd2);
    chk("b2b_wmask", 32'(release_wmask), 32'(4'b1000));
    cycle(0, 0, 0, 0, 1);
    check_model();

    // Asynchronous reset mid-cycle with a parked barrier and a pending release
    cycle(1, 2, 3, 1, 1);
    cycle(1, 2, 3, 2, 1);
    chk("pre_reset_stalled", 32'(stalled_wmask), 32'(4'b0110));
    cycle(1, 0, 0, 0, 0);
    check_model();
    barrier_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_release_valid", 32'(release_valid), 32'd0);
    chk("async_release_wmask", 32'(release_wmask), 32'd0);
    chk("async_stalled", 32'(stalled_wmask), 32'd0);
    chk("async_barrier_ready", 32'(barrier_ready), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1, 2, 1, 1, 1);
    chk("post_reset_park", 32'(stalled_wmask), 32'(4'b0010));
    chk("post_reset_no_release", 32'(release_valid), 32'd0);

    // Random legal traffic against the model
    for (int n = 0; n < 600; n++) begin
      int b, w, s;
      bit v, rr;
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      b  = $urandom_range(0, NUM_BARRIERS - 1);
      do w = $urandom_range(0, NUM_WARPS - 1); while (in_list(b, w));
      s  = (arr_q[b].size() != 0) ? sz[b] : $urandom_range(0, NUM_WARPS - 1);
      cycle(v, b, s, w, rr);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
